imm_decode_stage: RTL
=====================

# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage for the Mini RISC-V core. Sits between fetch and execute: accepts one 32-bit instruction per cycle over a valid/ready handshake and extracts the sign-extended immediate for every base-ISA format (I, S, B, U, J, R) at XLEN 32 or 64. Also classifies the format and flags unsupported opcodes. A 2-entry skid buffer gives full throughput under backpressure, and a synchronous flush drops in-flight entries on redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64; immediates sign-extended to XLEN.
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  drop all buffered entries; takes priority over in_valid.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format code from the package enum: R, I, S, B, U, J, NONE.
- out_illegal  out  1  opcode not in supported set.
- out_pc  out  XLEN  PC passed through.
- out_target  out  XLEN  out_pc + out_imm; present only with IMM_DECODE_PCREL_EN.

## Operation
- Opcode map, using in_instr[6:0]:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR → I: imm = sext(instr[31:20]).
  - 0100011 → S: imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111 LUI, 0010111 AUIPC → U: imm = sext({instr[31:12], 12'b0}).
  - 1101111 → J: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011 → R: imm = 0, legal.
  - Anything else → fmt NONE, imm = 0, out_illegal = 1.
- sext always replicates instr[31] up to XLEN-1. OP-IMM shifts are not special-cased.
- Handshake rules:
  - Input transfer when in_valid & in_ready & !flush.
  - Output transfer when out_valid & out_ready.
  - Entries leave in strict acceptance order.
- FSM, encoded as {main_valid, skid_valid}:
  - EMPTY: input transfer → ONE.
  - ONE, no transfers: hold.
  - ONE, input and output transfer in the same cycle: main reloads, stay ONE.
  - ONE, output transfer only → EMPTY.
  - ONE, input transfer with out_ready low: decoded word goes to skid → TWO.
  - TWO: in_ready = 0. Output transfer moves skid to main → ONE.
- flush in any state → EMPTY next cycle. An input presented in the same cycle is discarded.
- Reset mid-operation: both valids clear immediately and the stored entries are lost.
- Stored payload may be left stale when its valid is 0.

## Timing
- Latency: input transfer at edge N → out_valid at edge N+1.
- Throughput: 1 entry/cycle while out_ready is held high.
- in_ready is a register output, with no combinational path from out_ready.
- Reset values:
  - out_valid = 0, in_ready = 1.
  - out_imm, out_pc, out_target = 0.
  - out_fmt = NONE, out_illegal = 0.
- Payload outputs hold stable while out_valid & !out_ready.

## Configuration
- IMM_DECODE_PCREL_EN defined:
  - Adds an XLEN-bit adder and the out_target port.
  - out_target = out_pc + out_imm, wrapping modulo 2^XLEN, registered with the entry.
- IMM_DECODE_PCREL_EN undefined: port and adder absent; every other behaviour identical.

## Structure
- Package mini_rv_pkg holds:
  - Opcode localparams.
  - The 3-bit imm_fmt_e enum.
  - The XLEN legality check.
- Sub-module imm_extract: purely combinational instr → {imm, fmt, illegal}, parametrised by XLEN.
- The stage registers imm_extract's output rather than the raw instruction.

## Test plan
- Load: 0xFFC12083 (lw x1,-4(x2)), XLEN=32 → one cycle later out_imm = 0xFFFFFFFC, fmt I, illegal = 0.
- Store, branch and jump, XLEN=32:
  - 0x00512423 → imm 0x00000008, fmt S.
  - 0xFE000CE3 → imm 0xFFFFFFF8, fmt B.
  - 0x0010006F → imm 0x00000800, fmt J.
- Upper immediates:
  - 0x123450B7 → imm 0x12345000, fmt U.
  - XLEN=64 with 0x800000B7 → 0xFFFFFFFF80000000.
  - 0x0000007F → imm 0, fmt NONE, illegal = 1.
- Backpressure: hold out_ready = 0 and push A then B.
  - in_ready falls after B.
  - Raise out_ready → A then B on consecutive cycles, no loss or duplication.
- Flush and reset:
  - Flush while TWO, with in_valid = 1 the same cycle → out_valid = 0 next cycle, in_ready = 1, presented entry never appears.
  - rst_n pulsed while ONE → out_valid drops asynchronously.
- PCREL (IMM_DECODE_PCREL_EN): in_pc = 0x100 with 0xFE000CE3 → out_target = 0x000000F8.

Source files
------------

// File: rtl/mini_rv_pkg.sv
// rtl/mini_rv_pkg.sv - shared opcodes, immediate format enum and XLEN check for the Mini RISC-V core
//
// Purpose : common definitions imported by the immediate-decode stage.
// Contents: base-ISA opcode localparams, imm_fmt_e (3-bit format code),
//           stage_state_e (decode-stage occupancy, encoded {main_valid, skid_valid}),
//           xlen_is_legal() helper.
package mini_rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } imm_fmt_e;

  // Encoding is {main_valid, skid_valid}, so the valids fall straight out of the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } stage_state_e;

  function automatic bit xlen_is_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - fetch-to-execute handshake bundle of the immediate-decode stage
//
// Purpose : groups the upstream/downstream valid/ready handshake and payload.
// Modports: master - upstream/downstream environment (drives in_*, flush, out_ready)
//           slave  - the decode stage
// Signals : flush, in_valid, in_ready, in_instr[31:0], in_pc[XLEN-1:0],
//           out_valid, out_ready, out_imm, out_fmt, out_illegal, out_pc,
//           out_target (only when IMM_DECODE_PCREL_EN is defined).
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [XLEN-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_imm;
  mini_rv_pkg::imm_fmt_e  out_fmt;
  logic                   out_illegal;
  logic [XLEN-1:0]        out_pc;
`ifdef IMM_DECODE_PCREL_EN
  logic [XLEN-1:0]        out_target;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
  );
`else
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
  );
`endif

endinterface

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction and format classification
//
// Purpose : instr -> {sign-extended immediate, format, illegal flag}.
// Ports   : i_instr   [31:0]      instruction word
//           o_imm     [XLEN-1:0]  immediate, sign-extended from instr[31]
//           o_fmt     imm_fmt_e   R/I/S/B/U/J, NONE for unsupported opcodes
//           o_illegal             opcode outside the supported set
module imm_extract
  import mini_rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  // Each field is assembled at its natural width as a signed value; the size
  // cast then replicates instr[31] up to XLEN-1.
  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        o_imm = XLEN'($signed(i_instr[31:20]));
        o_fmt = FMT_I;
      end
      OPC_STORE: begin
        o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
        o_fmt = FMT_S;
      end
      OPC_BRANCH: begin
        o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
        o_fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
        o_fmt = FMT_U;
      end
      OPC_JAL: begin
        o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
        o_fmt = FMT_J;
      end
      OPC_OP: begin
        o_fmt = FMT_R;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate-decode stage with 2-entry skid buffer
//
// Purpose : decodes one instruction per cycle into {imm, fmt, illegal, pc} and
//           registers the result; a skid entry keeps full throughput under
//           backpressure while in_ready stays a pure register output.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    imm_decode_stage_if.slave (flush, in_*, out_*)
// Config  : IMM_DECODE_PCREL_EN adds out_target = out_pc + out_imm (mod 2^XLEN),
//           computed on the input side and registered with the entry.
module imm_decode_stage
  import mini_rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imm_decode_stage_if.slave     bus
);

  localparam bit XLEN_OK = xlen_is_legal(XLEN);

  if (!XLEN_OK) begin : g_xlen_illegal
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  // Decode of the incoming word
  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_illegal;

  imm_extract #(.XLEN(XLEN)) u_imm_extract (
    .i_instr   (bus.in_instr),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  // Occupancy state and handshake
  stage_state_e r_state;
  stage_state_e w_next_state;
  logic         w_main_valid;
  logic         w_skid_valid;
  logic         w_in_xfer;
  logic         w_out_xfer;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_skid_to_main;

  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_skid_valid = (r_state == ST_TWO);
  assign w_in_xfer    = bus.in_valid & ~w_skid_valid & ~bus.flush;
  assign w_out_xfer   = w_main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (bus.flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_load_main  = 1'b1;
            w_next_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            // Main drains and refills in the same edge; skid stays unused.
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_load_skid  = 1'b1;
            w_next_state = ST_TWO;
          end else if (w_out_xfer) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_xfer) begin
            w_skid_to_main = 1'b1;
            w_next_state   = ST_ONE;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
        end
      endcase
    end
  end

  // Payload registers; contents may be stale when the matching valid is low.
  logic [XLEN-1:0] r_main_imm;
  imm_fmt_e        r_main_fmt;
  logic            r_main_illegal;
  logic [XLEN-1:0] r_main_pc;
  logic [XLEN-1:0] r_skid_imm;
  imm_fmt_e        r_skid_fmt;
  logic            r_skid_illegal;
  logic [XLEN-1:0] r_skid_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_imm     <= '0;
      r_main_fmt     <= FMT_NONE;
      r_main_illegal <= 1'b0;
      r_main_pc      <= '0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= FMT_NONE;
      r_skid_illegal <= 1'b0;
      r_skid_pc      <= '0;
    end else begin
      if (w_load_main) begin
        r_main_imm     <= w_imm;
        r_main_fmt     <= w_fmt;
        r_main_illegal <= w_illegal;
        r_main_pc      <= bus.in_pc;
      end else if (w_skid_to_main) begin
        r_main_imm     <= r_skid_imm;
        r_main_fmt     <= r_skid_fmt;
        r_main_illegal <= r_skid_illegal;
        r_main_pc      <= r_skid_pc;
      end
      if (w_load_skid) begin
        r_skid_imm     <= w_imm;
        r_skid_fmt     <= w_fmt;
        r_skid_illegal <= w_illegal;
        r_skid_pc      <= bus.in_pc;
      end
    end
  end

`ifdef IMM_DECODE_PCREL_EN
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] r_main_target;
  logic [XLEN-1:0] r_skid_target;

  assign w_target = bus.in_pc + w_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_target <= '0;
      r_skid_target <= '0;
    end else begin
      if (w_load_main) begin
        r_main_target <= w_target;
      end else if (w_skid_to_main) begin
        r_main_target <= r_skid_target;
      end
      if (w_load_skid) begin
        r_skid_target <= w_target;
      end
    end
  end

  assign bus.out_target = r_main_target;
`endif

  assign bus.in_ready    = ~w_skid_valid;
  assign bus.out_valid   = w_main_valid;
  assign bus.out_imm     = r_main_imm;
  assign bus.out_fmt     = r_main_fmt;
  assign bus.out_illegal = r_main_illegal;
  assign bus.out_pc      = r_main_pc;

endmodule
